mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequential arbiter sharing the single main-memory port between the instruction-fetch requester and the data-access requester.
- Sits between core fetch/LSU and main memory; replaces combinational steering with registered grant, latched address/data, and a req/ready handshake.
- Data access has priority; a bounded fairness counter prevents fetch starvation.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, main memory read/write width
- MAX_DPRIO, 4, max consecutive data grants while a fetch is pending before fetch is forced
- TIMEOUT, 255, BUSY-cycle limit (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- imem_req  in  1  fetch request, held until imem_ready
- imem_addr  in  ADDR_W  fetch address
- imem_rdata  out  DATA_W  fetch data, valid while imem_ready
- imem_ready  out  1  one-cycle fetch completion pulse
- dmem_re  in  1  data read request, held until dmem_ready
- dmem_wr  in  1  data write request, held until dmem_ready
- dmem_addr  in  ADDR_W  data address
- dmem_wdata  in  DATA_W  write data
- dmem_rdata  out  DATA_W  read data, valid while dmem_ready
- dmem_ready  out  1  one-cycle data completion pulse
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_re  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, fairness count 0. Reset mid-transaction aborts it; no ready pulse is issued.
- States: IDLE, IBUSY, DBUSY, RESP.
- IDLE arbitration at clock edge:
  - Data request present and (no imem_req, or count < MAX_DPRIO): go to DBUSY.
  - Otherwise, if imem_req: go to IBUSY.
  - Otherwise stay in IDLE.
- On grant, mem_addr, mem_wdata and request type are latched. Later changes to the requester inputs are ignored until completion.
- dmem_re and dmem_wr asserted together are treated as a write; re is ignored.
- IBUSY: mem_re=1. DBUSY: mem_re=1 for a read; mem_wr=1 and mem_wdata driven for a write. Strobes are held until mem_ready is sampled high.
- mem_ready sampled high in BUSY:
  - Capture mem_rdata into the granted requester's rdata register (writes return 0).
  - Go to RESP and drop the strobes.
- RESP: the granted requester's ready is 1 for exactly one cycle; no arbitration. Next state is IDLE.
- rdata holds its value until the next completion for that port.
- mem_ready in IDLE or RESP is ignored.
- Minimum latency: request sampled at edge 0, mem_ready at edge 1, ready high in the cycle after edge 1. Throughput is one transaction per 3 cycles.
- Fairness count:
  - Increments on each data grant made while imem_req=1, saturating at MAX_DPRIO.
  - Clears on every fetch grant and whenever imem_req=0 in IDLE.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - Adds output port mem_timeout (1 bit).
  - A BUSY-cycle counter aborts the transaction when it reaches TIMEOUT without mem_ready.
  - On abort: go to RESP, rdata=0, ready pulses, and mem_timeout=1 for that same cycle.
- Without the macro: no mem_timeout port and no counter; BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants
  - requester ID constants (REQ_I, REQ_D)
  - MAIN_MEMORY_READ_SIZE default width
- Sub-module mem_arb_starve_ctr is the saturating fairness counter. It takes inc, clr and limit, and outputs force_i.
- FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Reset/idle: hold rst=0, then release with no requests → all outputs 0; mem_re=0 indefinitely.
- Single fetch: imem_req, addr 0x100, mem_rdata 0xDEADBEEF, mem_ready 2 cycles after grant → mem_addr=0x100, imem_rdata=0xDEADBEEF, imem_ready pulses exactly one cycle.
- Collision: imem_req and dmem_re assert in the same cycle → data granted first (mem_addr=dmem_addr), fetch serviced second.
- Starvation: imem_req held while dmem_re is re-asserted continuously → after 4 data grants the 5th grant goes to fetch (MAX_DPRIO=4).
- Write and conflict: dmem_wr=dmem_re=1, addr 0x2000, wdata 0x55AA → mem_wr=1, mem_re=0, dmem_ready pulses, dmem_rdata=0. Changing dmem_addr mid-BUSY does not alter mem_addr.
- Reset mid-op / timeout:
  - rst low during DBUSY → strobes drop immediately and no ready pulse follows.
  - With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, mem_ready never asserted → mem_timeout and dmem_ready pulse together after 8 BUSY cycles, with dmem_rdata=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester IDs and default widths for the memory arbiter
package mem_arb_pkg;
  localparam int MAIN_MEMORY_READ_SIZE = 32;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } state_e;
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of data grants made while a fetch waits; raises force_i at the limit
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic         force_i
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d   = clr_i ? '0 : (inc_i && cnt_q < limit_i) ? cnt_q + 1'b1 : cnt_q;
  assign force_i = cnt_q >= limit_i;
  // count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: registered fetch/data arbiter for one memory port; MEM_ARB_TIMEOUT_EN adds a BUSY timeout and mem_timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = MAIN_MEMORY_READ_SIZE,
  parameter int MAX_DPRIO = 4
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_ready,
  input  logic              dmem_re,
  input  logic              dmem_wr,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              mem_timeout
`endif
);
  localparam int CW = $clog2(MAX_DPRIO + 1);
  state_e            state_q, state_d;
  logic              gid_q, gid_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, irdata_q, irdata_d, drdata_q, drdata_d, rdat;
  logic              idle, busy, dreq, gnt_dat, gnt_ins, done, force_i;

  assign idle    = state_q == IDLE;
  assign busy    = state_q == IBUSY || state_q == DBUSY;
  assign dreq    = dmem_re | dmem_wr;
  assign gnt_dat = idle && dreq && (!imem_req || !force_i);
  assign gnt_ins = idle && imem_req && !gnt_dat;

  mem_arb_starve_ctr #(.W(CW)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (gnt_dat && imem_req),
    .clr_i   (gnt_ins || (idle && !imem_req)),
    .limit_i (CW'(MAX_DPRIO)),
    .force_i (force_i)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          to_q, abort;
  assign abort       = busy && !mem_ready && tmr_q == TW'(TIMEOUT - 1);
  assign tmr_d       = busy ? tmr_q + 1'b1 : '0;
  assign done        = busy && (mem_ready || abort);
  assign rdat        = (wr_q || abort) ? '0 : mem_rdata;
  assign mem_timeout = to_q;
  // BUSY cycle counter; the abort flag is shown during the following RESP cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tmr_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      to_q  <= abort;
    end
`else
  assign done = busy && mem_ready;
  assign rdat = wr_q ? '0 : mem_rdata;
`endif

  // next state: grant and latch the request in IDLE, capture read data on completion
  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    if (gnt_dat) begin
      state_d = DBUSY;
      gid_d   = REQ_D;
      wr_d    = dmem_wr;
      addr_d  = dmem_addr;
      wdata_d = dmem_wr ? dmem_wdata : '0;
    end else if (gnt_ins) begin
      state_d = IBUSY;
      gid_d   = REQ_I;
      wr_d    = 1'b0;
      addr_d  = imem_addr;
      wdata_d = '0;
    end
    if (done) begin
      state_d  = RESP;
      irdata_d = gid_q == REQ_I ? rdat : irdata_q;
      drdata_d = gid_q == REQ_D ? rdat : drdata_q;
    end
    if (state_q == RESP) state_d = IDLE;
  end

  // state and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      gid_q    <= REQ_I;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_re     = busy && !wr_q;
  assign mem_wr     = busy && wr_q;
  assign imem_rdata = irdata_q;
  assign dmem_rdata = drdata_q;
  assign imem_ready = state_q == RESP && gid_q == REQ_I;
  assign dmem_ready = state_q == RESP && gid_q == REQ_D;
endmodule
